// File: rtl/tlk2711_axi_mem_slave.sv
// AXI4 memory responder standing in for the DDR/HP0 port behind tlk2711_top.
// Optional random wait states: define TLK_AXI_STALL_EN.
module tlk2711_axi_mem_slave #(
  parameter int          ADDR_WIDTH = 40,
  parameter int          DATA_WIDTH = 128,
  parameter int          DEPTH      = 4096,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [3:0]              s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic [3:0]              s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [3:0]              s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [31:0]             o_rd_bursts,
  output logic [31:0]             o_wr_bursts
);
  localparam int         STRB_W    = DATA_WIDTH / 8;
  localparam int         LOG2B     = $clog2(STRB_W);
  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [2:0] SIZE_FULL = 3'(LOG2B);

  typedef enum logic       {R_IDLE, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_stall;
`ifdef TLK_AXI_STALL_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk) begin
    if (!rst) r_lfsr <= LFSR_SEED;
    else      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  logic w_unused_seed;
  assign w_unused_seed = ^LFSR_SEED;
  assign w_stall       = 1'b0;
`endif

  // Byte lanes below the beat size and address bits above the array are ignored.
  logic w_unused_addr;
  assign w_unused_addr = ^{s_axi_araddr[LOG2B-1:0], s_axi_araddr[ADDR_WIDTH-1:LOG2B+IDX_W],
                           s_axi_awaddr[LOG2B-1:0], s_axi_awaddr[ADDR_WIDTH-1:LOG2B+IDX_W]};

  // ---------------- read channel ----------------
  rstate_t               r_rstate, w_rnext;
  logic [3:0]            r_rid;
  logic [IDX_W-1:0]      r_ridx;
  logic [7:0]            r_rlen, r_rcnt;
  logic                  r_rfixed, r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic [31:0]           r_rd_bursts;

  logic [IDX_W-1:0] w_ar_idx, w_ridx_nxt;
  logic             w_r_hs, w_r_last;
  assign w_ar_idx   = s_axi_araddr[LOG2B +: IDX_W];
  assign w_r_hs     = r_rvalid & s_axi_rready;
  assign w_r_last   = (r_rcnt == r_rlen);
  assign w_ridx_nxt = r_rfixed ? r_ridx : r_ridx + IDX_W'(1);

  always_comb begin
    w_rnext       = r_rstate;
    s_axi_arready = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) w_rnext = R_DATA;
      end
      R_DATA: if (w_r_hs && w_r_last) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rstate    <= R_IDLE;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_rresp     <= 2'b00;
      r_rid       <= 4'd0;
      r_ridx      <= '0;
      r_rlen      <= 8'd0;
      r_rcnt      <= 8'd0;
      r_rfixed    <= 1'b0;
      r_rd_bursts <= 32'd0;
    end else begin
      r_rstate <= w_rnext;
      case (r_rstate)
        R_IDLE: if (s_axi_arvalid) begin
          r_rid    <= s_axi_arid;
          r_ridx   <= w_ar_idx;
          r_rlen   <= s_axi_arlen;
          r_rcnt   <= 8'd0;
          r_rfixed <= (s_axi_arburst == 2'b00);
          r_rresp  <= (s_axi_arsize != SIZE_FULL) ? 2'b10 : 2'b00;
          r_rvalid <= !w_stall;
          r_rdata  <= r_mem[w_ar_idx];
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (w_r_last) begin
              r_rvalid    <= 1'b0;
              r_rd_bursts <= r_rd_bursts + 32'd1;
            end else begin
              r_ridx   <= w_ridx_nxt;
              r_rcnt   <= r_rcnt + 8'd1;
              r_rvalid <= !w_stall;
              r_rdata  <= r_mem[w_ridx_nxt];
            end
          end else if (!r_rvalid && !w_stall) begin
            // A beat deferred by a stall is fetched when it is actually presented.
            r_rvalid <= 1'b1;
            r_rdata  <= r_mem[r_ridx];
          end
        end
        default: ;
      endcase
    end
  end

  assign s_axi_rid    = r_rid;
  assign s_axi_rdata  = r_rdata;
  assign s_axi_rresp  = r_rresp;
  assign s_axi_rvalid = r_rvalid;
  assign s_axi_rlast  = r_rvalid & w_r_last;
  assign o_rd_bursts  = r_rd_bursts;

  // ---------------- write channel ----------------
  wstate_t          r_wstate, w_wnext;
  logic [3:0]       r_wid;
  logic [IDX_W-1:0] r_widx;
  logic [7:0]       r_wlen, r_wcnt;
  logic             r_wfixed, r_werr, r_wserr, r_bvalid;
  logic [31:0]      r_wr_bursts;

  logic w_w_hs, w_w_end, w_b_hs;
  assign w_w_hs  = s_axi_wvalid & s_axi_wready;
  assign w_w_end = s_axi_wlast | (r_wcnt == r_wlen);
  assign w_b_hs  = r_bvalid & s_axi_bready;

  always_comb begin
    w_wnext       = r_wstate;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) w_wnext = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = !w_stall;
        if (w_w_hs && w_w_end) w_wnext = W_RESP;
      end
      W_RESP: if (w_b_hs) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wstate    <= W_IDLE;
      r_bvalid    <= 1'b0;
      r_werr      <= 1'b0;
      r_wserr     <= 1'b0;
      r_wid       <= 4'd0;
      r_widx      <= '0;
      r_wlen      <= 8'd0;
      r_wcnt      <= 8'd0;
      r_wfixed    <= 1'b0;
      r_wr_bursts <= 32'd0;
    end else begin
      r_wstate <= w_wnext;
      case (r_wstate)
        W_IDLE: if (s_axi_awvalid) begin
          r_wid    <= s_axi_awid;
          r_widx   <= s_axi_awaddr[LOG2B +: IDX_W];
          r_wlen   <= s_axi_awlen;
          r_wcnt   <= 8'd0;
          r_wfixed <= (s_axi_awburst == 2'b00);
          r_werr   <= 1'b0;
          r_wserr  <= (s_axi_awsize != SIZE_FULL);
        end
        W_DATA: if (w_w_hs) begin
          if (s_axi_wlast != (r_wcnt == r_wlen)) r_werr <= 1'b1;
          r_widx <= r_wfixed ? r_widx : r_widx + IDX_W'(1);
          r_wcnt <= r_wcnt + 8'd1;
          if (w_w_end) r_bvalid <= !w_stall;
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_bvalid    <= 1'b0;
            r_wr_bursts <= r_wr_bursts + 32'd1;
          end else if (!r_bvalid && !w_stall) begin
            r_bvalid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Array write lands at the edge, so a read fetched in the same cycle sees the old word.
  always_ff @(posedge clk) begin
    if (rst && w_w_hs) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) r_mem[r_widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi_bid    = r_wid;
  assign s_axi_bresp  = (r_werr | r_wserr) ? 2'b10 : 2'b00;
  assign s_axi_bvalid = r_bvalid;
  assign o_wr_bursts  = r_wr_bursts;

endmodule

// File: tb/tb_tlk2711_axi_mem_slave.sv
// Directed and randomized bench for tlk2711_axi_mem_slave against a word-array reference model.
module tb_tlk2711_axi_mem_slave;
  localparam int AW = 40, DW = 128, DEPTH = 4096, SW = DW / 8;

  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] arid = '0, awid = '0;
  logic [AW-1:0] araddr = '0, awaddr = '0;
  logic [7:0] arlen = '0, awlen = '0;
  logic [2:0] arsize = '0, awsize = '0;
  logic [1:0] arburst = '0, awburst = '0;
  logic arvalid = 1'b0, awvalid = 1'b0, rready = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic arready, awready, rvalid, rlast, wready, bvalid;
  logic [3:0] rid, bid;
  logic [DW-1:0] rdata;
  logic [1:0] rresp, bresp;
  logic [31:0] rd_bursts, wr_bursts;

  tlk2711_axi_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .o_rd_bursts(rd_bursts), .o_wr_bursts(wr_bursts)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, rd_exp = 0, wr_exp = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wd [256];
  logic [SW-1:0] ws [256];
  localparam int BOUND = 300;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int word_of(input logic [AW-1:0] a);
    return int'((a / SW) % DEPTH);
  endfunction

  // Issues a write burst; wlast is raised on beat last_at (or never if last_at < 0).
  task automatic axi_write(input string tag, input logic [AW-1:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int last_at,
                           output logic [1:0] resp);
    int n, nbeats, idx;
    logic [3:0] id;
    id = 4'($urandom);
    nbeats = (last_at >= 0 && last_at <= int'(len)) ? last_at + 1 : int'(len) + 1;
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) chk({tag, "_aw_timeout"}, awready, 1'b1);
    tick();
    awvalid = 1'b0;
    idx = word_of(a);
    for (int b = 0; b < nbeats; b++) begin
      if ($urandom_range(3) == 0) begin wvalid = 1'b0; tick(); end
      wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wlast = (b == last_at);
      n = 0;
      while (!wready && n < BOUND) begin tick(); n++; end
      if (n >= BOUND) chk({tag, "_w_timeout"}, wready, 1'b1);
      tick();
      for (int k = 0; k < SW; k++)
        if (ws[b][k]) model[idx][k*8 +: 8] = wd[b][k*8 +: 8];
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk({tag, "_no_extra_wready"}, wready, 1'b0);
    for (int d = $urandom_range(2); d > 0; d--) tick();
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) chk({tag, "_b_timeout"}, bvalid, 1'b1);
    resp = bresp;
    chk({tag, "_bid"}, bid, id);
    tick();
    bready = 1'b0;
    wr_exp++;
    chk({tag, "_wr_bursts"}, wr_bursts, wr_exp);
  endtask

  // mode 0: rready held high, 1: toggling 1010..., 2: random
  task automatic axi_read(input string tag, input logic [AW-1:0] a, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input int mode);
    int n, beat, idx, cyc;
    logic [3:0] id;
    logic hold, hold_last;
    logic [DW-1:0] hold_data;
    id = 4'($urandom);
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) chk({tag, "_ar_timeout"}, arready, 1'b1);
    tick();
    arvalid = 1'b0;
    idx = word_of(a); beat = 0; cyc = 0; hold = 1'b0; hold_last = 1'b0; hold_data = '0;
    while (beat <= int'(len) && cyc < 4 * BOUND) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (cyc % 2 == 0);
        default: rready = 1'($urandom);
      endcase
      if (hold) begin
        chk({tag, "_hold_valid"}, rvalid, 1'b1);
        chk({tag, "_hold_data"}, rdata, hold_data);
        chk({tag, "_hold_last"}, rlast, hold_last);
      end
      hold = rvalid && !rready; hold_data = rdata; hold_last = rlast;
      if (rvalid && rready) begin
        chk($sformatf("%s_data%0d", tag, beat), rdata, model[idx]);
        chk($sformatf("%s_last%0d", tag, beat), rlast, beat == int'(len));
        chk($sformatf("%s_resp%0d", tag, beat), rresp, (size == 3'd4) ? 2'b00 : 2'b10);
        chk({tag, "_rid"}, rid, id);
        beat++;
        if (burst != 2'b00) idx = (idx + 1) % DEPTH;
      end
      tick(); cyc++;
    end
    rready = 1'b0;
    if (beat <= int'(len)) chk({tag, "_r_timeout"}, beat, int'(len) + 1);
    chk({tag, "_no_extra_beat"}, rvalid, 1'b0);
    rd_exp++;
    chk({tag, "_rd_bursts"}, rd_bursts, rd_exp);
  endtask

  initial begin
    logic [1:0] resp;
    int n, beats, base;
    logic [7:0] len;
    logic [1:0] bt;

    // Reset state
    rst = 1'b0; tick(); tick();
    chk("rst_arready", arready, 1'b1);
    chk("rst_awready", awready, 1'b1);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rdata", rdata, '0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rd_bursts", rd_bursts, 32'd0);
    chk("rst_wr_bursts", wr_bursts, 32'd0);
    rst = 1'b1; tick();

    // Reset mid-burst: 16-beat read, reset while beat 5 is presented
    arid = 4'd5; araddr = 40'h1000; arlen = 8'd15; arsize = 3'd4; arburst = 2'b01; arvalid = 1'b1;
    tick(); arvalid = 1'b0; rready = 1'b1;
    beats = 0; n = 0;
    while (beats < 4 && n < BOUND) begin if (rvalid) beats++; tick(); n++; end
    n = 0;
    while (!rvalid && n < BOUND) begin tick(); n++; end
    chk("midrst_beat5_valid", rvalid, 1'b1);
    rst = 1'b0; tick();
    chk("midrst_rvalid", rvalid, 1'b0);
    chk("midrst_rlast", rlast, 1'b0);
    chk("midrst_arready", arready, 1'b1);
    chk("midrst_rd_bursts", rd_bursts, 32'd0);
    rst = 1'b1; rready = 1'b0; tick();

    // Preload the random-test region with 64 full-strobe words
    for (int i = 0; i < 64; i++) begin
      wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = '1;
    end
    axi_write("preload", 40'h3000, 8'd63, 2'b01, 3'd4, 63, resp);
    chk("preload_bresp", resp, 2'b00);

    // Write then read: 0x100, four beats 0..3
    for (int i = 0; i < 4; i++) begin wd[i] = DW'(i); ws[i] = '1; end
    axi_write("wr_basic", 40'h100, 8'd3, 2'b01, 3'd4, 3, resp);
    chk("wr_basic_bresp", resp, 2'b00);
    axi_read("rd_basic", 40'h100, 8'd3, 2'b01, 3'd4, 0);
    chk("rd_basic_word3", model[19], DW'(3));

    // Byte strobes on word 0x20
    wd[0] = '1; ws[0] = '1;
    axi_write("strb_pre", 40'h200, 8'd0, 2'b01, 3'd4, 0, resp);
    wd[0] = '0; ws[0] = 16'h00F0;
    axi_write("strb", 40'h200, 8'd0, 2'b01, 3'd4, 0, resp);
    chk("strb_model", model[32], 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF);
    axi_read("strb_rd", 40'h200, 8'd0, 2'b01, 3'd4, 0);

    // INCR wrap from word DEPTH-2
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = '1; end
    axi_write("wrap", 40'((DEPTH - 2) * SW), 8'd3, 2'b01, 3'd4, 3, resp);
    chk("wrap_word1", model[1], wd[3]);
    axi_read("wrap_rd", 40'((DEPTH - 2) * SW), 8'd3, 2'b01, 3'd4, 2);
    axi_read("wrap_rd0", 40'h0, 8'd1, 2'b01, 3'd4, 0);

    // Protocol errors
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = '1; end
    axi_write("early_wlast", 40'h3100, 8'd3, 2'b01, 3'd4, 1, resp);
    chk("early_wlast_bresp", resp, 2'b10);
    axi_write("no_wlast", 40'h3140, 8'd1, 2'b01, 3'd4, -1, resp);
    chk("no_wlast_bresp", resp, 2'b10);
    axi_write("bad_awsize", 40'h3180, 8'd0, 2'b01, 3'd3, 0, resp);
    chk("bad_awsize_bresp", resp, 2'b10);
    axi_read("bad_arsize", 40'h100, 8'd3, 2'b01, 3'd3, 0);

    // FIXED bursts: last write wins, reads repeat one word
    for (int i = 0; i < 3; i++) begin wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = 16'($urandom); end
    axi_write("fixed", 40'h3208, 8'd2, 2'b00, 3'd4, 2, resp);
    chk("fixed_bresp", resp, 2'b00);
    axi_read("fixed_rd", 40'h3200, 8'd2, 2'b00, 3'd4, 1);

    // Randomized bursts inside the preloaded region with backpressure
    for (int t = 0; t < 12; t++) begin
      base = 40'h3000 + $urandom_range(55) * SW + $urandom_range(SW - 1);
      len = 8'($urandom_range(7));
      bt = 2'($urandom);
      for (int i = 0; i <= int'(len); i++) begin
        wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = 16'($urandom);
      end
      axi_write($sformatf("rnd%0d_w", t), 40'(base), len, bt, 3'd4, int'(len), resp);
      chk($sformatf("rnd%0d_bresp", t), resp, 2'b00);
      axi_read($sformatf("rnd%0d_r", t), 40'(base), len, bt, 3'd4, 1 + (t % 2));
    end

    chk("final_rd_bursts", rd_bursts, rd_exp);
    chk("final_wr_bursts", wr_bursts, wr_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
